// File: rtl/pendulum_pkg.sv
// Shared constants, fixed-point formats and step FSM encoding for the
// pendulum driver and its physics simulation unit.
package pendulum_pkg;

  // Mechanical resolution: 3200 steps per revolution, 0.1125 deg per step.
  localparam int STEPS_PER_REV = 3200;
  localparam int HALF_REV      = 1600;

  // Q16.16 speed / acceleration, Q12.16 position.
  localparam int FRAC_BITS     = 16;
  localparam int POS_INT_BITS  = 12;
  localparam int POS_BITS      = POS_INT_BITS + FRAC_BITS;

  // Speed saturates at +/-3199.0 steps/tick so one update never moves the
  // position by a full revolution or more.
  localparam logic signed [31:0] SPEED_LIMIT = 32'sd209649664;  // 3199 << 16
  // One full revolution in Q12.16.
  localparam logic signed [31:0] POS_WRAP    = 32'sd209715200;  // 3200 << 16

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_t;

  // Parabolic sine approximation over half a revolution:
  // s = 4*a*(1600-a)/1600^2 in Q1.15, i.e. a*(1600-a)*64/1250.
  // Peak (a = 800) is exactly 1.0 = 32768, hence 17 result bits.
  function automatic logic [16:0] gravity_shape(input logic [10:0] a);
    logic [31:0] prod;
    prod = 32'(a) * (32'd1600 - 32'(a));
    return 17'((prod << 6) / 32'd1250);
  endfunction

endpackage

// File: rtl/pendulum_sim.sv
// Physics integrator: gravity from the folded position, lever acceleration,
// semi-implicit Euler update of speed then position on every strobe.
module pendulum_sim
  import pendulum_pkg::*;
#(
  parameter int          leverADCBits = 16,
  parameter logic [31:0] gravityAcc   = 32'h0000_0800,
  parameter int          accShift     = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sim_clock_sync,
  input  logic signed [leverADCBits-1:0] al1Bits,
  input  logic signed [leverADCBits-1:0] al2Bits,
  output logic signed [31:0]             integrated_speed,
  output logic [11:0]                    current_pos
);

  localparam logic signed [32:0] SAT_HI = 33'sd209649664;

  logic [POS_BITS-1:0] integrated_pos;
  logic                lower_half;
  logic [10:0]         fold_a;
  logic [16:0]         shape;
  logic [31:0]         grav_mag;
  logic signed [31:0]  gravity;
  logic signed [31:0]  lever_sum;
  logic signed [31:0]  lever_acc;
  logic signed [31:0]  total_acc;
  logic signed [32:0]  speed_sum;
  logic signed [31:0]  speed_next;
  logic signed [31:0]  pos_sum;
  logic signed [31:0]  pos_wrapped;

  assign current_pos = integrated_pos[POS_BITS-1:FRAC_BITS];

  // Fold the position onto half a revolution; the lower half pulls the
  // pendulum back down toward 0, the upper half pushes it on toward 3200.
  assign lower_half = current_pos < 12'(HALF_REV);
  assign fold_a     = lower_half ? current_pos[10:0]
                                 : 11'(current_pos - 12'(HALF_REV));
  assign shape      = gravity_shape(fold_a);
  assign grav_mag   = 32'((64'(gravityAcc) * 64'(shape)) >> 15);
  assign gravity    = lower_half ? -$signed(grav_mag) : $signed(grav_mag);

  // Both lever inputs are sign-extended to 32 bits before summing so the
  // sum cannot overflow the input width.
  assign lever_sum = {{(32-leverADCBits){al1Bits[leverADCBits-1]}}, al1Bits}
                   + {{(32-leverADCBits){al2Bits[leverADCBits-1]}}, al2Bits};
  assign lever_acc = lever_sum <<< accShift;
  assign total_acc = gravity + lever_acc;

  // Candidate next state: saturating speed, then position with the new speed
  // wrapped back into [0, 3200.0). One correction suffices because
  // |speed| < 3200.0.
  always_comb begin
    speed_sum  = {integrated_speed[31], integrated_speed} + {total_acc[31], total_acc};
    speed_next = speed_sum[31:0];
    if (speed_sum > SAT_HI) begin
      speed_next = SPEED_LIMIT;
    end else if (speed_sum < -SAT_HI) begin
      speed_next = -SPEED_LIMIT;
    end
    pos_sum     = $signed({4'b0000, integrated_pos}) + speed_next;
    pos_wrapped = pos_sum;
    if (pos_sum < 0) begin
      pos_wrapped = pos_sum + POS_WRAP;
    end else if (pos_sum >= POS_WRAP) begin
      pos_wrapped = pos_sum - POS_WRAP;
    end
  end

  // Integrator state advances only in the strobe clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      integrated_speed <= '0;
      integrated_pos   <= '0;
    end else if (sim_clock_sync) begin
      integrated_speed <= speed_next;
      integrated_pos   <= POS_BITS'(pos_wrapped);
    end
  end

endmodule

// File: rtl/pendulum_driver.sv
// Pendulum stepper driver: physics tick generator, simulation unit and a
// step/dir FSM that chases the simulated position one step at a time.
module pendulum_driver
  import pendulum_pkg::*;
#(
  parameter int          simPeriod    = 500_000,
  parameter int          leverADCBits = 16,
  parameter logic [31:0] gravityAcc   = 32'h0000_0800,
  parameter int          accShift     = 8,
  parameter int          stepHigh     = 100,
  parameter int          stepPeriod   = 2500
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [leverADCBits-1:0] al1Bits,
  input  logic signed [leverADCBits-1:0] al2Bits,
  output logic                           step,
  output logic                           dir,
  output logic [1:0]                     dbg_state,
  output logic                           dbg_tick,
  output logic [31:0]                    dbg_speed,
  output logic [11:0]                    dbg_pos,
  output logic [11:0]                    dbg_motor_pos
);

  localparam int TICK_W = (simPeriod > 1) ? $clog2(simPeriod) : 1;
  localparam int CNT_W  = $clog2(stepPeriod + 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic               sim_clock_sync;
  logic signed [31:0] integrated_speed;
  logic [11:0]        current_pos;

  step_state_t        state, state_next;
  logic [11:0]        motor_pos, motor_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               dir_next;
  logic               step_next;
  logic signed [12:0] raw_delta;
  logic signed [12:0] delta_steps;

  // Physics tick: one-clock strobe after every simPeriod clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt       <= '0;
      sim_clock_sync <= 1'b0;
    end else if (tick_cnt == TICK_W'(simPeriod - 1)) begin
      tick_cnt       <= '0;
      sim_clock_sync <= 1'b1;
    end else begin
      tick_cnt       <= tick_cnt + TICK_W'(1);
      sim_clock_sync <= 1'b0;
    end
  end

  pendulum_sim #(
    .leverADCBits (leverADCBits),
    .gravityAcc   (gravityAcc),
    .accShift     (accShift)
  ) SIMULATION_UNIT (
    .clock            (clock),
    .reset            (reset),
    .sim_clock_sync   (sim_clock_sync),
    .al1Bits          (al1Bits),
    .al2Bits          (al2Bits),
    .integrated_speed (integrated_speed),
    .current_pos      (current_pos)
  );

  // Shortest signed path from the motor to the simulated position,
  // folded into [-1600, +1599].
  always_comb begin
    raw_delta   = $signed({1'b0, current_pos}) - $signed({1'b0, motor_pos});
    delta_steps = raw_delta;
    if (raw_delta > 13'sd1599) begin
      delta_steps = raw_delta - 13'sd3200;
    end else if (raw_delta < -13'sd1600) begin
      delta_steps = raw_delta + 13'sd3200;
    end
  end

  // Step FSM next state. dir takes its new value as the FSM enters SETUP,
  // so it is stable for a full clock before step rises. motor_pos moves on
  // the SETUP->HIGH edge, so a reset during the pulse never leaves a
  // half-counted step. cnt counts clocks since the rising edge of step.
  always_comb begin
    state_next = state;
    motor_next = motor_pos;
    cnt_next   = cnt;
    dir_next   = dir;
    step_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (delta_steps != 13'sd0) begin
          state_next = ST_SETUP;
          dir_next   = delta_steps > 13'sd0;
        end
      end
      ST_SETUP: begin
        state_next = ST_HIGH;
        step_next  = 1'b1;
        cnt_next   = '0;
        if (dir) begin
          motor_next = (motor_pos == 12'(STEPS_PER_REV - 1)) ? 12'd0 : motor_pos + 12'd1;
        end else begin
          motor_next = (motor_pos == 12'd0) ? 12'(STEPS_PER_REV - 1) : motor_pos - 12'd1;
        end
      end
      ST_HIGH: begin
        cnt_next  = cnt + CNT_W'(1);
        step_next = 1'b1;
        if (cnt == CNT_W'(stepHigh - 1)) begin
          state_next = ST_LOW;
          step_next  = 1'b0;
        end
      end
      ST_LOW: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(stepPeriod - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Step FSM registers; step is a flop so the pin never glitches on decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      motor_pos <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
    end else begin
      state     <= state_next;
      motor_pos <= motor_next;
      cnt       <= cnt_next;
      dir       <= dir_next;
      step      <= step_next;
    end
  end

  assign dbg_state     = state;
  assign dbg_tick      = sim_clock_sync;
  assign dbg_speed     = integrated_speed;
  assign dbg_pos       = current_pos;
  assign dbg_motor_pos = motor_pos;

endmodule

// File: tb/tb_pendulum_driver.sv
// Bench for pendulum_driver: one instance without gravity for exact
// kinematics, one with default gravity for the restoring-force check.
module tb_pendulum_driver;
  import pendulum_pkg::*;

  localparam int SIM_PERIOD  = 200;
  localparam int STEP_HIGH   = 4;
  localparam int STEP_PERIOD = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] al1 = '0;
  logic signed [15:0] al2 = '0;

  logic step_ng, dir_ng, tick_ng;
  logic [1:0]  state_ng;
  logic [31:0] speed_ng;
  logic [11:0] pos_ng, motor_ng;
  logic step_g, dir_g, tick_g;
  logic [1:0]  state_g;
  logic [31:0] speed_g;
  logic [11:0] pos_g, motor_g;

  pendulum_driver #(
    .simPeriod (SIM_PERIOD), .leverADCBits (16), .gravityAcc (32'h0),
    .accShift (8), .stepHigh (STEP_HIGH), .stepPeriod (STEP_PERIOD)
  ) dut_ng (
    .clock (clock), .reset (reset), .al1Bits (al1), .al2Bits (al2),
    .step (step_ng), .dir (dir_ng), .dbg_state (state_ng), .dbg_tick (tick_ng),
    .dbg_speed (speed_ng), .dbg_pos (pos_ng), .dbg_motor_pos (motor_ng)
  );

  pendulum_driver #(
    .simPeriod (SIM_PERIOD), .leverADCBits (16), .gravityAcc (32'h0000_0800),
    .accShift (8), .stepHigh (STEP_HIGH), .stepPeriod (STEP_PERIOD)
  ) dut_g (
    .clock (clock), .reset (reset), .al1Bits (al1), .al2Bits (al2),
    .step (step_g), .dir (dir_g), .dbg_state (state_g), .dbg_tick (tick_g),
    .dbg_speed (speed_g), .dbg_pos (pos_g), .dbg_motor_pos (motor_g)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int edges_ng = 0;
  int edges_g  = 0;
  int base_ng  = 0;
  int base_g   = 0;
  always @(posedge step_ng) edges_ng++;
  always @(posedge step_g)  edges_g++;

  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];

  typedef struct {
    logic signed [15:0] a1;
    logic signed [15:0] a2;
    logic [31:0]        spd;
    logic [11:0]        pos;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    al1 = '0;
    al2 = '0;
    repeat (2) @(negedge clock);
    check("rst_state", 64'(state_ng), 64'(ST_IDLE));
    check("rst_step",  64'(step_ng), 64'd0);
    check("rst_dir",   64'(dir_ng), 64'd0);
    check("rst_speed", 64'(speed_ng), 64'd0);
    check("rst_pos",   64'(pos_ng), 64'd0);
    check("rst_motor", 64'(motor_ng), 64'd0);
    reset = 1'b1;
    base_ng = edges_ng;
    base_g  = edges_g;
  endtask

  // Waits for the strobe, then returns #1 after the edge that applies it.
  task automatic wait_tick();
    int n;
    n = 0;
    while (tick_ng !== 1'b1 && n < SIM_PERIOD + 20) begin
      @(negedge clock);
      n++;
    end
    if (tick_ng !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no strobe after %0d clocks, expected one", n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic score_tick(input string tag);
    logic [43:0] e;
    e = exp_q.pop_front();
    check({tag, "_speed"}, 64'(speed_ng), 64'(e[43:12]));
    check({tag, "_pos"},   64'(pos_ng),   64'(e[11:0]));
  endtask

  // Driver: apply one table row per tick.
  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      al1 = vecs[i].a1;
      al2 = vecs[i].a2;
      exp_q.push_back({vecs[i].spd, vecs[i].pos});
      wait_tick();
      score_tick($sformatf("%s_row%0d", tag, i));
    end
  endtask

  // Driver with a reference integrator (gravity-free), starting from reset.
  task automatic run_model(input logic signed [15:0] a1, input logic signed [15:0] a2,
                           input int n, input string tag);
    longint sp, pf, acc, lim, wrap;
    sp = 0;
    pf = 0;
    lim  = 64'sd3199 * 64'sd65536;
    wrap = 64'sd3200 * 64'sd65536;
    acc  = (longint'(a1) + longint'(a2)) * 256;
    for (int k = 0; k < n; k++) begin
      sp = sp + acc;
      if (sp > lim) sp = lim;
      if (sp < -lim) sp = -lim;
      pf = pf + sp;
      if (pf < 0) pf = pf + wrap;
      else if (pf >= wrap) pf = pf - wrap;
      al1 = a1;
      al2 = a2;
      exp_q.push_back({32'(sp), 12'(pf >> 16)});
      wait_tick();
      score_tick($sformatf("%s_t%0d", tag, k + 1));
    end
  endtask

  task automatic wait_step_rise(input string tag);
    int n;
    n = 0;
    while (step_ng !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_step_rise"}, 64'(step_ng), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, prev, cur;
    // Rows 0-4: idle; 5-7: constant +1.0 push; 8-17: cancelling levers.
    for (int i = 0; i < 5; i++) vecs[i] = '{16'sd0, 16'sd0, 32'h0, 12'd0};
    vecs[5] = '{16'sd256, 16'sd0, 32'h0001_0000, 12'd1};
    vecs[6] = '{16'sd256, 16'sd0, 32'h0002_0000, 12'd3};
    vecs[7] = '{16'sd256, 16'sd0, 32'h0003_0000, 12'd6};
    for (int i = 8; i < 18; i++) vecs[i] = '{16'sd256, -16'sd256, 32'h0, 12'd0};

    // At rest, nothing moves.
    do_reset();
    run_rows(0, 4, "rest");
    check("rest_edges_ng", 64'(edges_ng - base_ng), 64'd0);
    check("rest_edges_g",  64'(edges_g - base_g), 64'd0);
    check("rest_dir",      64'(dir_ng), 64'd0);

    // Constant push: speed 1/2/3, position 1/3/6, motor follows.
    do_reset();
    run_rows(5, 7, "push");
    al1 = '0;
    repeat (60) @(negedge clock);
    check("push_edges", 64'(edges_ng - base_ng), 64'd6);
    check("push_motor", 64'(motor_ng), 64'd6);
    check("push_dir",   64'(dir_ng), 64'd1);
    check("push_idle",  64'(state_ng), 64'(ST_IDLE));

    // Cancelling levers over 10 ticks.
    do_reset();
    run_rows(8, 17, "cancel");
    check("cancel_edges", 64'(edges_ng - base_ng), 64'd0);

    // Backward wrap: one step from 0 to 3199.
    do_reset();
    al1 = -16'sd256;
    exp_q.push_back({32'hFFFF_0000, 12'd3199});
    wait_tick();
    al1 = '0;
    score_tick("wrap");
    wait_step_rise("wrap");
    check("wrap_dir", 64'(dir_ng), 64'd0);
    w = 0;
    while (step_ng === 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("wrap_pulse_width", 64'(w), 64'(STEP_HIGH));
    repeat (20) @(negedge clock);
    check("wrap_motor", 64'(motor_ng), 64'd3199);
    check("wrap_edges", 64'(edges_ng - base_ng), 64'd1);

    // Speed saturation in both directions, with position wrapping each tick.
    do_reset();
    run_model(16'sd32767, 16'sd32767, 14, "satp");
    do_reset();
    run_model(-16'sd32768, -16'sd32768, 14, "satn");

    // Gravity restores toward the bottom once the push stops.
    do_reset();
    al1 = 16'sd256;
    wait_tick();
    check("grav_bottom_speed", 64'(speed_g), 64'h0001_0000);
    wait_tick();
    wait_tick();
    al1 = '0;
    prev = int'($signed(speed_g));
    check("grav_below_3", 64'(prev < 196608), 64'd1);
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      cur = int'($signed(speed_g));
      check($sformatf("grav_restore_%0d", k), 64'(cur < prev), 64'd1);
      prev = cur;
    end

    // Reset in the middle of a step pulse.
    do_reset();
    al1 = 16'sd256;
    wait_tick();
    al1 = '0;
    wait_step_rise("midrst");
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_step",  64'(step_ng), 64'd0);
    check("midrst_state", 64'(state_ng), 64'(ST_IDLE));
    check("midrst_dir",   64'(dir_ng), 64'd0);
    check("midrst_speed", 64'(speed_ng), 64'd0);
    check("midrst_pos",   64'(pos_ng), 64'd0);
    check("midrst_motor", 64'(motor_ng), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    base_ng = edges_ng;
    repeat (20) @(negedge clock);
    check("midrst_motor_after", 64'(motor_ng), 64'd0);
    check("midrst_edges_after", 64'(edges_ng - base_ng), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
